the_ffm: RTL and testbench

// - Four-channel UART telemetry collector. Polls four sensor UARTs, assembles a 60-byte snapshot and

---
 rtl/the_ffm.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_the_ffm.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/the_ffm.sv
// the_ffm: four-channel UART telemetry collector for the Orbita serial line.
// Every poll period the four sensor UARTs are asked for data (dRX pulse), up to NBYTES bytes per
// channel are collected, and at the next poll tick the collected bytes are sent as one frame:
// ORB_HDR followed by ch1..ch4 fields, every byte MSB first, each bit held ORB_DIV cycles.
// Optional build macro SYNC_CHECK_EN: a channel whose bytes 0, 5 and 10 are not all 8'h55 is sent
// as all zeros. Without it, bytes are sent unchecked.
// BAUD_DIV and ORB_DIV must be at least 2; NBYTES must be at least 11 when SYNC_CHECK_EN is set.
module the_ffm #(
    parameter int unsigned POLL_DIV = 80000,
    parameter int unsigned REQ_LEN  = 80,
    parameter int unsigned BAUD_DIV = 16,
    parameter int unsigned NBYTES   = 15,
    parameter int unsigned ORB_DIV  = 25,
    parameter logic [7:0]  ORB_HDR  = 8'hE1
) (
    input  logic clk80,
    input  logic rst_n,
    input  logic UART1_RX,
    input  logic UART3_RX,
    input  logic UART4_RX,
    input  logic UART5_RX,
    output logic UART1_dRX,
    output logic UART3_dRX,
    output logic UART4_dRX,
    output logic UART5_dRX,
    output logic Orb_serial
);

    localparam int unsigned NCH   = 4;
    localparam int unsigned NSLOT = NCH * NBYTES;
    localparam int unsigned PW    = $clog2(POLL_DIV);
    localparam int unsigned RW    = $clog2(REQ_LEN + 1);
    localparam int unsigned BW    = $clog2(BAUD_DIV);
    localparam int unsigned CW    = $clog2(NBYTES + 1);
    // frame byte index: 0 is the header, 1..NSLOT are snapshot bytes
    localparam int unsigned SW    = $clog2(NSLOT + 1);
    localparam int unsigned OW    = $clog2(ORB_DIV);

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

    logic [NCH-1:0]        rx_in;
    logic [NCH-1:0]        armed_q;
    logic [NCH-1:0]        rx_ok;
    logic [NCH-1:0][7:0]   rx_byte;

    assign rx_in = {UART5_RX, UART4_RX, UART3_RX, UART1_RX};

    // ------------------------------------------------------------------ poll timing
    logic [PW-1:0] poll_q;
    logic          tick;

    assign tick = (poll_q == PW'(POLL_DIV - 1));

    // Free-running poll period counter; wraps on the tick
    always_ff @(posedge clk80) begin
        if (!rst_n) begin
            poll_q <= '0;
        end else if (tick) begin
            poll_q <= '0;
        end else begin
            poll_q <= poll_q + 1'b1;
        end
    end

    logic [RW-1:0] req_q;
    logic          drx_q;
    logic          drx_fall;

    // request pulse ends at this edge; receivers arm here
    assign drx_fall = drx_q && (req_q == '0) && !tick;

    // Data request pulse: high for exactly REQ_LEN cycles starting at the tick
    always_ff @(posedge clk80) begin
        if (!rst_n) begin
            drx_q <= 1'b0;
            req_q <= '0;
        end else if (tick) begin
            drx_q <= 1'b1;
            req_q <= RW'(REQ_LEN - 1);
        end else if (req_q != '0) begin
            req_q <= req_q - 1'b1;
        end else begin
            drx_q <= 1'b0;
        end
    end

    assign UART1_dRX = drx_q;
    assign UART3_dRX = drx_q;
    assign UART4_dRX = drx_q;
    assign UART5_dRX = drx_q;

    // ------------------------------------------------------------------ UART receivers
    for (genvar c = 0; c < NCH; c++) begin : g_rx
        // [0] first sync flop, [1] synchronised level, [2] previous synchronised level
        logic [2:0]    sync_q;
        rx_state_e     st_q;
        logic [BW-1:0] bcnt_q;
        logic [2:0]    bit_q;
        logic [7:0]    sh_q;

        // Start detect, half-bit recheck, mid-bit data sampling, stop-bit sampling
        always_ff @(posedge clk80) begin
            if (!rst_n) begin
                sync_q <= 3'b111;
                st_q   <= RxIdle;
                bcnt_q <= '0;
                bit_q  <= '0;
                sh_q   <= '0;
            end else begin
                sync_q <= {sync_q[1:0], rx_in[c]};
                unique case (st_q)
                    RxIdle: begin
                        if (armed_q[c] && sync_q[2] && !sync_q[1]) begin
                            st_q   <= RxStart;
                            bcnt_q <= '0;
                        end
                    end
                    RxStart: begin
                        if (bcnt_q == BW'(BAUD_DIV / 2 - 1)) begin
                            bcnt_q <= '0;
                            bit_q  <= '0;
                            st_q   <= sync_q[1] ? RxIdle : RxData;
                        end else begin
                            bcnt_q <= bcnt_q + 1'b1;
                        end
                    end
                    RxData: begin
                        if (bcnt_q == BW'(BAUD_DIV - 1)) begin
                            bcnt_q <= '0;
                            sh_q   <= {sync_q[1], sh_q[7:1]};
                            bit_q  <= bit_q + 1'b1;
                            if (bit_q == 3'd7) begin
                                st_q <= RxStop;
                            end
                        end else begin
                            bcnt_q <= bcnt_q + 1'b1;
                        end
                    end
                    RxStop: begin
                        if (bcnt_q == BW'(BAUD_DIV - 1)) begin
                            bcnt_q <= '0;
                            st_q   <= RxIdle;
                        end else begin
                            bcnt_q <= bcnt_q + 1'b1;
                        end
                    end
                    default: st_q <= RxIdle;
                endcase
            end
        end

        // good byte: stop bit sampled high
        assign rx_ok[c]   = (st_q == RxStop) && (bcnt_q == BW'(BAUD_DIV - 1)) && sync_q[1];
        assign rx_byte[c] = sh_q;
    end

    // ------------------------------------------------------------------ receive buffer
    logic [NSLOT-1:0][7:0]  rx_buf_q;
    logic [NCH-1:0][CW-1:0] cnt_q;

    // Collect good bytes per channel; the tick clears everything and wins over a store
    always_ff @(posedge clk80) begin
        if (!rst_n) begin
            rx_buf_q <= '0;
            cnt_q    <= '0;
            armed_q  <= '0;
        end else if (tick) begin
            rx_buf_q <= '0;
            cnt_q    <= '0;
            armed_q  <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (drx_fall) begin
                    armed_q[c] <= 1'b1;
                end else if (armed_q[c] && rx_ok[c]) begin
                    rx_buf_q[SW'(c * NBYTES) + SW'(cnt_q[c])] <= rx_byte[c];
                    cnt_q[c] <= cnt_q[c] + 1'b1;
                    if (cnt_q[c] == CW'(NBYTES - 1)) begin
                        armed_q[c] <= 1'b0;
                    end
                end
            end
        end
    end

    logic [NSLOT-1:0][7:0] snap_src;

    // Snapshot contents as they will be sent
    always_comb begin
        snap_src = rx_buf_q;
`ifdef SYNC_CHECK_EN
        for (int c = 0; c < NCH; c++) begin
            if (rx_buf_q[c * NBYTES] != 8'h55 || rx_buf_q[c * NBYTES + 5] != 8'h55 ||
                rx_buf_q[c * NBYTES + 10] != 8'h55) begin
                for (int b = 0; b < NBYTES; b++) begin
                    snap_src[c * NBYTES + b] = 8'h00;
                end
            end
        end
`endif
    end

    // ------------------------------------------------------------------ snapshot / serializer
    logic [NSLOT-1:0][7:0] tx_snap_q;
    logic [NSLOT-1:0][7:0] pend_q;
    logic                  pend_vld_q;
    logic                  snap_go_q;
    logic                  ser_busy_q;
    logic [SW-1:0]         byte_q;
    logic [2:0]            bit_q;
    logic [OW-1:0]         div_q;
    logic                  orb_q;
    logic                  ser_done;
    logic [7:0]            cur_byte;
    logic [7:0]            next_byte;

    assign ser_done = ser_busy_q && (div_q == OW'(ORB_DIV - 1)) && (bit_q == 3'd0) &&
                      (byte_q == SW'(NSLOT));

    // Snapshot load; a tick during a frame is parked until the frame ends (newest wins)
    always_ff @(posedge clk80) begin
        if (!rst_n) begin
            tx_snap_q  <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            snap_go_q  <= 1'b0;
        end else begin
            snap_go_q <= 1'b0;
            if (tick) begin
                if ((ser_busy_q && !ser_done) || snap_go_q) begin
                    pend_q     <= snap_src;
                    pend_vld_q <= 1'b1;
                end else begin
                    tx_snap_q  <= snap_src;
                    pend_vld_q <= 1'b0;
                    snap_go_q  <= 1'b1;
                end
            end else if (ser_done && pend_vld_q) begin
                tx_snap_q  <= pend_q;
                pend_vld_q <= 1'b0;
                snap_go_q  <= 1'b1;
            end
        end
    end

    // Byte currently on the line and the one after it
    always_comb begin
        cur_byte  = ORB_HDR;
        next_byte = 8'h00;
        if (byte_q != '0) begin
            cur_byte = tx_snap_q[byte_q - 1'b1];
        end
        if (byte_q < SW'(NSLOT)) begin
            next_byte = tx_snap_q[byte_q];
        end
    end

    // Frame serializer: header then snapshot bytes, MSB first, ORB_DIV cycles per bit
    always_ff @(posedge clk80) begin
        if (!rst_n) begin
            ser_busy_q <= 1'b0;
            byte_q     <= '0;
            bit_q      <= '0;
            div_q      <= '0;
            orb_q      <= 1'b1;
        end else if (!ser_busy_q) begin
            orb_q <= 1'b1;
            if (snap_go_q) begin
                ser_busy_q <= 1'b1;
                byte_q     <= '0;
                bit_q      <= 3'd7;
                div_q      <= '0;
                orb_q      <= ORB_HDR[7];
            end
        end else if (div_q != OW'(ORB_DIV - 1)) begin
            div_q <= div_q + 1'b1;
        end else begin
            div_q <= '0;
            if (bit_q != 3'd0) begin
                bit_q <= bit_q - 1'b1;
                orb_q <= cur_byte[bit_q - 1'b1];
            end else if (byte_q == SW'(NSLOT)) begin
                ser_busy_q <= 1'b0;
                orb_q      <= 1'b1;
            end else begin
                byte_q <= byte_q + 1'b1;
                bit_q  <= 3'd7;
                orb_q  <= next_byte[7];
            end
        end
    end

    assign Orb_serial = orb_q;

endmodule

// File: tb/tb_the_ffm.sv
// tb_the_ffm: directed bench for the_ffm with shortened timing parameters.
module tb_the_ffm;

    localparam int unsigned POLL_DIV   = 3000;
    localparam int unsigned REQ_LEN    = 20;
    localparam int unsigned BAUD_DIV   = 8;
    localparam int unsigned NBYTES     = 15;
    localparam int unsigned ORB_DIV    = 4;
    localparam int unsigned FRAME_BITS = 488;

    // hand-written byte fields, byte 0 in the top byte
    localparam logic [119:0] SEQ1  = 120'h55_91_92_93_94_55_95_96_97_98_55_99_9A_9B_9C;
    localparam logic [119:0] SEQB  = 120'h55_01_02_03_04_55_05_06_07_08_55_09_0A_0B_0C;
    localparam logic [119:0] SEQD  = 120'h55_01_02_03_04_54_05_06_07_08_55_09_0A_0B_0C;
    localparam logic [119:0] SEQE  = 120'h55_31_32_33_34_35_55_36_37_38_39_55_3A_3B_3C;
    localparam logic [119:0] SEQED = 120'h55_31_32_33_35_55_36_37_38_39_55_3A_3B_3C_00;

    logic        clk80 = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  rx_line = 4'hF;
    logic        d1, d3, d4, d5, orb;
    int unsigned cyc = 0;
    int          n_total = 0;
    int          n_bad = 0;

    the_ffm #(
        .POLL_DIV (POLL_DIV),
        .REQ_LEN  (REQ_LEN),
        .BAUD_DIV (BAUD_DIV),
        .NBYTES   (NBYTES),
        .ORB_DIV  (ORB_DIV),
        .ORB_HDR  (8'hE1)
    ) dut (
        .clk80      (clk80),
        .rst_n      (rst_n),
        .UART1_RX   (rx_line[0]),
        .UART3_RX   (rx_line[1]),
        .UART4_RX   (rx_line[2]),
        .UART5_RX   (rx_line[3]),
        .UART1_dRX  (d1),
        .UART3_dRX  (d3),
        .UART4_dRX  (d4),
        .UART5_dRX  (d5),
        .Orb_serial (orb)
    );

    always #5 clk80 = ~clk80;
    always @(posedge clk80) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Step negedges until dRX goes high; returns cycle count at that negedge
    task automatic wait_tick(output int unsigned at);
        int unsigned n;
        n = 0;
        while (d1 !== 1'b1 && n < POLL_DIV + 200) begin
            @(negedge clk80);
            n++;
        end
        at = cyc;
        check_eq("tick_seen", 128'(d1), 128'd1);
    endtask

    // Called at the negedge right after the tick edge; samples each bit mid-way
    task automatic capture(output logic [FRAME_BITS-1:0] bits);
        bits = '0;
        repeat (2) @(negedge clk80);
        for (int i = 0; i < FRAME_BITS; i++) begin
            bits = {bits[FRAME_BITS-2:0], orb};
            if (i != FRAME_BITS - 1) repeat (ORB_DIV) @(negedge clk80);
        end
    endtask

    task automatic measure_width(output int unsigned w);
        w = 0;
        while (d1 === 1'b1 && w < 1000) begin
            w++;
            @(negedge clk80);
        end
    endtask

    task automatic send_bit(input int ch, input logic v);
        rx_line[ch] = v;
        repeat (BAUD_DIV) @(negedge clk80);
    endtask

    // Wait for the request to end, then send nb bytes; byte index 'bad' gets a 0 stop bit
    task automatic send_ch(input int ch, input logic [127:0] data, input int nb, input int bad);
        int unsigned n;
        logic [7:0]  b;
        n = 0;
        while (d1 !== 1'b0 && n < 1000) begin
            @(negedge clk80);
            n++;
        end
        repeat (2) @(negedge clk80);
        for (int i = 0; i < nb; i++) begin
            b = data[127 - 8 * i -: 8];
            send_bit(ch, 1'b0);
            for (int k = 0; k < 8; k++) send_bit(ch, b[k]);
            send_bit(ch, (i == bad) ? 1'b0 : 1'b1);
            send_bit(ch, 1'b1);
            send_bit(ch, 1'b1);
        end
    endtask

    task automatic check_frame(input string tag, input logic [FRAME_BITS-1:0] bits,
                               input logic [479:0] ef);
        check_eq({tag, "_hdr"}, 128'(bits[487:480]), 128'(8'hE1));
        for (int c = 0; c < 4; c++) begin
            check_eq($sformatf("%s_ch%0d", tag, c + 1), 128'(bits[479 - 120 * c -: 120]),
                     128'(ef[479 - 120 * c -: 120]));
        end
    endtask

    initial begin
        logic [FRAME_BITS-1:0] fb;
        logic [119:0]          exp_ch2;
        int unsigned           t_rel, t_tick, t_prev, w, zeros, highs;

        repeat (5) @(negedge clk80);
        check_eq("rst_orb", 128'(orb), 128'd1);
        check_eq("rst_drx", 128'({d5, d4, d3, d1}), 128'd0);
        rst_n = 1'b1;
        t_rel = cyc;

        // poll 1: idle frame, request pulse width, ch1 sends SEQ1
        wait_tick(t_tick);
        check_eq("first_tick", 128'(t_tick - t_rel), 128'(POLL_DIV));
        t_prev = t_tick;
        check_eq("drx_all_high", 128'({d5, d4, d3, d1}), 128'hF);
        fork
            capture(fb);
            measure_width(w);
            send_ch(0, {SEQ1, 8'h00}, 15, -1);
        join
        check_eq("drx_width", 128'(w), 128'(REQ_LEN));
        check_frame("idle", fb, '0);

        // poll 2: frame carries SEQ1 on ch1; all four channels send SEQB
        wait_tick(t_tick);
        check_eq("period", 128'(t_tick - t_prev), 128'(POLL_DIV));
        t_prev = t_tick;
        fork
            capture(fb);
            send_ch(0, {SEQB, 8'h00}, 15, -1);
            send_ch(1, {SEQB, 8'h00}, 15, -1);
            send_ch(2, {SEQB, 8'h00}, 15, -1);
            send_ch(3, {SEQB, 8'h00}, 15, -1);
        join
        check_frame("ch1", fb, {SEQ1, 360'd0});

        // poll 3: frame of four SEQB; ch1 overruns, ch2 breaks sync, ch3 has a framing error
        wait_tick(t_tick);
        check_eq("period2", 128'(t_tick - t_prev), 128'(POLL_DIV));
        fork
            capture(fb);
            send_ch(0, {SEQB, 8'hEE}, 16, -1);
            send_ch(1, {SEQD, 8'h00}, 15, -1);
            send_ch(2, {SEQE, 8'h00}, 15, 4);
        join
        check_frame("all4", fb, {SEQB, SEQB, SEQB, SEQB});

        // poll 4: mixed frame
`ifdef SYNC_CHECK_EN
        exp_ch2 = '0;
`else
        exp_ch2 = SEQD;
`endif
        wait_tick(t_tick);
        capture(fb);
        check_frame("mixed", fb, {SEQB, exp_ch2, SEQED, 120'd0});

        // poll 5: one-cycle reset in the middle of the frame and the request pulse
        wait_tick(t_tick);
        repeat (6) @(negedge clk80);
        rst_n = 1'b0;
        @(negedge clk80);
        rst_n = 1'b1;
        t_rel = cyc;
        check_eq("midrst_orb", 128'(orb), 128'd1);
        check_eq("midrst_drx", 128'({d5, d4, d3, d1}), 128'd0);
        zeros = 0;
        highs = 0;
        repeat (POLL_DIV - 50) begin
            @(negedge clk80);
            if (orb !== 1'b1) zeros++;
            if (d1 !== 1'b0) highs++;
        end
        check_eq("quiet_orb", 128'(zeros), 128'd0);
        check_eq("quiet_drx", 128'(highs), 128'd0);
        wait_tick(t_tick);
        check_eq("tick_after_rst", 128'(t_tick - t_rel), 128'(POLL_DIV));
        capture(fb);
        check_frame("post_rst", fb, '0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
